// File: rtl/incrementor_pkg.sv
// Shared arithmetic package for the incrementor and its adder/subtractor
// siblings.
//   INC_WIDTH  : default operand width for the incrementor.
//   ARITH_MAXW : widest operand any helper here can describe.
//   all_ones() : returns the all-ones value for a given width. The value is
//                right-aligned in an ARITH_MAXW-bit word, so callers
//                truncate it to their own width.
package incrementor_pkg;

  localparam int INC_WIDTH  = 4;
  localparam int ARITH_MAXW = 64;

  function automatic logic [ARITH_MAXW-1:0] all_ones(input int unsigned w);
    logic [ARITH_MAXW-1:0] ones;
    ones = '1;
    if (w >= ARITH_MAXW) return ones;
    return ones >> (ARITH_MAXW - w);
  endfunction

endpackage

// File: rtl/incrementor_if.sv
// Operand/result bundle for the incrementor.
//   in_valid : operand qualifier
//   inp      : unsigned operand
//   out_valid: result qualifier
//   o        : registered result
//   carry    : registered carry-out / saturation flag
// The master modport is the producer side (drives the operand). The slave
// modport is the incrementor.
interface incrementor_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] inp;
  logic             out_valid;
  logic [WIDTH-1:0] o;
  logic             carry;

  modport master (output in_valid, output inp,
                  input  out_valid, input o, input carry);
  modport slave  (input  in_valid, input inp,
                  output out_valid, output o, output carry);
endinterface

// File: rtl/incrementor_core.sv
// Combinational +1 core: a ripple chain of half adders with carry-in = 1.
//   a    : operand
//   sum  : a + 1 truncated to WIDTH
//   cout : carry-out of the MSB stage (set only when a is all-ones)
module incrementor_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // c[i] is the carry into bit i. The constant 1 into bit 0 is the "+1".
  logic [WIDTH:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    assign sum[i]  = a[i] ^ c[i];
    assign c[i+1]  = a[i] & c[i];
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/incrementor.sv
// Registered unsigned incrementor: o = inp + 1, with a one-cycle latency and
// full throughput.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset. It clears o, carry and out_valid.
//   bus   : incrementor_if slave (in_valid/inp in; out_valid/o/carry out)
// SATURATE=0 wraps all-ones to zero. SATURATE=1 holds all-ones. In both
// modes carry is set when the operand was all-ones.
module incrementor
  import incrementor_pkg::*;
#(
  parameter int WIDTH    = INC_WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  incrementor_if.slave bus
);

  localparam int STAGES = 1;
  localparam logic [WIDTH-1:0] ONES = WIDTH'(all_ones(WIDTH));

  logic [WIDTH-1:0] sum;
  logic             cout;

  incrementor_core #(.WIDTH(WIDTH)) u_core (
    .a    (bus.inp),
    .sum  (sum),
    .cout (cout)
  );

  logic [WIDTH-1:0] o_d, o_q;
  logic             carry_d, carry_q;

  // The carry-out is only ever set for an all-ones operand. In saturate
  // mode, that case is clamped back to all-ones.
  always_comb begin
    o_d     = sum;
    carry_d = cout;
    if (SATURATE && cout) o_d = ONES;
  end

  // vld_pipe[0] is the live input qualifier. The higher bits are registered.
  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;

  assign vld_pipe = {vld_q, bus.in_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
    end
  end

  // The data registers load only on a valid operand, so an X operand while
  // idle never reaches state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q     <= '0;
      carry_q <= 1'b0;
    end else if (bus.in_valid) begin
      o_q     <= o_d;
      carry_q <= carry_d;
    end
  end

  assign bus.o         = o_q;
  assign bus.carry     = carry_q;
  assign bus.out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_incrementor.sv
module tb_incrementor;
  import incrementor_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  incrementor_if #(.WIDTH(4)) wif ();
  incrementor_if #(.WIDTH(4)) sif ();

  incrementor #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wif)
  );

  incrementor #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Both DUTs always see the same operand.
  task automatic drive(input logic v, input logic [3:0] x);
    wif.in_valid = v; wif.inp = x;
    sif.in_valid = v; sif.inp = x;
  endtask

  // Advance one rising edge, then settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 4'd5);
    tick(); tick();
    checks++; if (wif.o !== 4'd0) begin errors++; $display("FAIL reset_o got=%0d exp=0", wif.o); end
    checks++; if (wif.carry !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b exp=0", wif.carry); end
    checks++; if (wif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov got=%b exp=0", wif.out_valid); end
    checks++; if (sif.o !== 4'd0) begin errors++; $display("FAIL reset_sat_o got=%0d exp=0", sif.o); end
    rst_n = 1'b1;
    tick();
    // First capture after release: 5 -> 6.
    checks++; if (wif.o !== 4'd6 || wif.out_valid !== 1'b1) begin errors++; $display("FAIL post_release got=%0d/%b exp=6/1", wif.o, wif.out_valid); end
    // Assert reset between edges; the outputs must clear without a clock.
    drive(1'b1, 4'd15);
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wif.o !== 4'd0 || wif.carry !== 1'b0 || wif.out_valid !== 1'b0) begin errors++; $display("FAIL async_reset got o=%0d c=%b v=%b exp 0/0/0", wif.o, wif.carry, wif.out_valid); end
    tick();
    rst_n = 1'b1;
    drive(1'b0, 4'd0);
  endtask

  task automatic test_sweep();
    logic [3:0] exp_o;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i));
      tick();
      exp_o = (i == 15) ? 4'd0 : 4'(i + 1);
      checks++; if (wif.o !== exp_o) begin errors++; $display("FAIL sweep_o in=%0d got=%0d exp=%0d", i, wif.o, exp_o); end
      checks++; if (wif.carry !== (i == 15)) begin errors++; $display("FAIL sweep_carry in=%0d got=%b exp=%b", i, wif.carry, (i == 15)); end
      checks++; if (wif.out_valid !== 1'b1) begin errors++; $display("FAIL sweep_ov in=%0d got=%b exp=1", i, wif.out_valid); end
    end
    // Right after the wrap: 0 -> 1, carry clears.
    drive(1'b1, 4'd0);
    tick();
    checks++; if (wif.o !== 4'd1 || wif.carry !== 1'b0) begin errors++; $display("FAIL after_wrap got=%0d/%b exp=1/0", wif.o, wif.carry); end
  endtask

  task automatic test_valid_gating();
    drive(1'b1, 4'd3);
    tick();
    checks++; if (wif.o !== 4'd4 || wif.out_valid !== 1'b1) begin errors++; $display("FAIL gate_load got=%0d/%b exp=4/1", wif.o, wif.out_valid); end
    drive(1'b0, 4'd9);
    tick();
    checks++; if (wif.o !== 4'd4) begin errors++; $display("FAIL gate_hold_o got=%0d exp=4", wif.o); end
    checks++; if (wif.out_valid !== 1'b0) begin errors++; $display("FAIL gate_ov got=%b exp=0", wif.out_valid); end
    checks++; if (wif.carry !== 1'b0) begin errors++; $display("FAIL gate_carry got=%b exp=0", wif.carry); end
    // An X operand while idle must not disturb state.
    drive(1'b0, 4'bxxxx);
    tick();
    checks++; if (wif.o !== 4'd4 || wif.carry !== 1'b0) begin errors++; $display("FAIL x_idle got=%b/%b exp=0100/0", wif.o, wif.carry); end
  endtask

  task automatic test_saturate();
    drive(1'b1, 4'd15);
    tick();
    checks++; if (sif.o !== 4'd15 || sif.carry !== 1'b1) begin errors++; $display("FAIL sat_15 got=%0d/%b exp=15/1", sif.o, sif.carry); end
    checks++; if (sif.out_valid !== 1'b1) begin errors++; $display("FAIL sat_ov got=%b exp=1", sif.out_valid); end
    checks++; if (wif.o !== 4'd0 || wif.carry !== 1'b1) begin errors++; $display("FAIL wrap_15 got=%0d/%b exp=0/1", wif.o, wif.carry); end
    drive(1'b1, 4'd14);
    tick();
    checks++; if (sif.o !== 4'd15 || sif.carry !== 1'b0) begin errors++; $display("FAIL sat_14 got=%0d/%b exp=15/0", sif.o, sif.carry); end
    drive(1'b1, 4'd6);
    tick();
    checks++; if (sif.o !== 4'd7 || sif.carry !== 1'b0) begin errors++; $display("FAIL sat_6 got=%0d/%b exp=7/0", sif.o, sif.carry); end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 4'd2);
    tick();
    checks++; if (wif.o !== 4'd3) begin errors++; $display("FAIL mid_2 got=%0d exp=3", wif.o); end
    drive(1'b1, 4'd3);
    tick();
    checks++; if (wif.o !== 4'd4) begin errors++; $display("FAIL mid_3 got=%0d exp=4", wif.o); end
    drive(1'b1, 4'd4);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wif.o !== 4'd0 || wif.out_valid !== 1'b0 || wif.carry !== 1'b0) begin errors++; $display("FAIL mid_clear got o=%0d v=%b c=%b exp 0/0/0", wif.o, wif.out_valid, wif.carry); end
    tick();
    checks++; if (wif.o !== 4'd0 || wif.out_valid !== 1'b0) begin errors++; $display("FAIL mid_held got=%0d/%b exp=0/0", wif.o, wif.out_valid); end
    rst_n = 1'b1;
    drive(1'b0, 4'd4);
    tick();
    // Nothing is replayed after release.
    checks++; if (wif.o !== 4'd0 || wif.out_valid !== 1'b0) begin errors++; $display("FAIL no_replay got=%0d/%b exp=0/0", wif.o, wif.out_valid); end
    drive(1'b1, 4'd10);
    tick();
    checks++; if (wif.o !== 4'd11 || wif.out_valid !== 1'b1 || wif.carry !== 1'b0) begin errors++; $display("FAIL mid_10 got o=%0d v=%b c=%b exp 11/1/0", wif.o, wif.out_valid, wif.carry); end
    drive(1'b0, 4'd0);
  endtask

  // Consecutive valid operands each produce a result one edge later.
  task automatic test_back_to_back();
    logic [3:0] vec [4] = '{4'd8, 4'd9, 4'd15, 4'd1};
    logic [3:0] exp [4] = '{4'd9, 4'd10, 4'd0, 4'd2};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vec[i]);
      tick();
      checks++; if (wif.o !== exp[i] || wif.out_valid !== 1'b1) begin errors++; $display("FAIL b2b in=%0d got=%0d/%b exp=%0d/1", vec[i], wif.o, wif.out_valid, exp[i]); end
    end
    drive(1'b0, 4'd0);
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b0, 4'd0);
    test_reset();
    test_sweep();
    test_valid_gating();
    test_saturate();
    test_reset_midstream();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/incrementor.md
Name: incrementor

Overview:
- Registered unsigned +1 incrementor: `o` = `inp` + 1, modulo 2^WIDTH.
- Exposes a carry/wrap flag and a registered output valid.
- Serves as a small arithmetic leaf block, e.g. counter next-state or pointer advance, in the adder/subtractor family.
- Default build is 4-bit with wrap-around; saturation is optional.

Parameters:
- WIDTH, 4, operand and result width in bits (≥1).
- SATURATE, 0, 0 = wrap all-ones to zero; 1 = hold all-ones, no wrap.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  `inp` is valid this cycle.
- inp  input  WIDTH  unsigned operand.
- out_valid  output  1  `o`/`carry` hold a fresh result.
- o  output  WIDTH  registered result.
- carry  output  1  registered carry-out (`inp` was all-ones).

Behaviour:
- Reset: asserting `rst_n`=0 immediately (asynchronously) forces `o`=0, `carry`=0, `out_valid`=0. Release is taken synchronously, so the first capture happens on the first rising edge after `rst_n`=1.
- Capture: on a rising edge with `in_valid`=1:
  - `o` <= `inp`+1 truncated to WIDTH.
  - `carry` <= 1 iff `inp` == 2^WIDTH−1, else 0.
  - `out_valid` <= 1.
- Latency is exactly 1 cycle, with full throughput: a new operand is accepted every cycle. There is no backpressure and no ready signal.
- Idle: on a rising edge with `in_valid`=0, `out_valid` <= 0. `o` and `carry` hold their previous values.
- Wrap (SATURATE=0): `inp`=all-ones gives `o`=0, `carry`=1.
- Saturate (SATURATE=1): `inp`=all-ones gives `o`=all-ones, `carry`=1, so `carry` doubles as a saturation flag.
- Arithmetic:
  - Pure unsigned; no sign interpretation.
  - Computed as a half-adder ripple chain with carry-in fixed at 1.
  - Final carry is the carry-out of the MSB stage.
- Reset mid-stream: any in-flight result is discarded and outputs return to reset values within the same cycle. Nothing is replayed after reset.
- X-safety: when `in_valid`=0, `inp` may be X without affecting state.
- No other internal state; no FSM.

Decomposition:
- Shared package (e.g. `arith_pkg`):
  - Default width constant INC_WIDTH=4.
  - A function returning the all-ones value for a width.
  - Reused by the adder/subtractor blocks.
- One natural sub-module, `incrementor_core`:
  - Purely combinational, parameter WIDTH.
  - Ports: `a[WIDTH-1:0]`, `sum[WIDTH-1:0]`, `cout`.
  - Built from a generate loop of half-adder stages.
  - The top level adds the saturation mux and the output registers.

Test Plan:
- Reset: hold `rst_n`=0 with `in_valid`=1, `inp`=5 → `o`=0, `carry`=0, `out_valid`=0. Assert `rst_n` asynchronously between edges → outputs clear without waiting for a clock.
- Full sweep, WIDTH=4: drive `inp`=0..15 with `in_valid`=1, one value per cycle, each held ≥1 cycle → one cycle later `o`=`inp`+1 for 0..14 with `carry`=0. E.g. 0→1, 7→8, 14→15.
- Wrap boundary: `inp`=15 → `o`=0, `carry`=1, `out_valid`=1. Next `inp`=0 → `o`=1, `carry`=0.
- Valid gating: apply `inp`=3 valid, then `in_valid`=0 with `inp`=9 → `o` stays 4, `out_valid` drops to 0 on the second edge.
- Saturate build (SATURATE=1, WIDTH=4): `inp`=15 → `o`=15, `carry`=1. `inp`=14 → `o`=15, `carry`=0.
- Reset mid-stream: back-to-back valid inputs 2,3,4, with `rst_n` pulsed low during the 3 → 4 cycle → outputs clear immediately. After release, the first new operand `inp`=10 gives `o`=11 one cycle later.
